kdw_loader: RTL

Upstream fill engine for the depthwise-kernel tile RAM. On a start pulse it fetches a depthwise kernel tile from external memory in channel-major order: channel, then ky, then kx. It writes each weight into the tile RAM in position-major order, so the DW convolution engine can read all channels of one kernel tap contiguously. It sits between the external memory read port and the tile RAM write port, and signals completion with a one-cycle done pulse.

---
 rtl/kdw_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/kdw_loader.sv
// Depthwise-kernel tile loader: fetches weights channel-major from external memory
// and writes them position-major (tap*N_CH + channel) into the tile RAM.
module kdw_loader #(
  parameter int WG_W = 8,
  parameter int K    = 3,
  parameter int N_CH = 16,
  parameter int MA_W = 32,
  localparam int KK         = K * K,
  localparam int KDW_N_ELEM = KK * N_CH,
  localparam int NCH_W      = $clog2(N_CH + 1),
  localparam int KA_W       = $clog2(KDW_N_ELEM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MA_W-1:0]  base_addr,
  input  logic [NCH_W-1:0] n_ch,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic [MA_W-1:0]  mem_addr,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [WG_W-1:0]  mem_rdata,
  output logic [KA_W-1:0]  kdw_addr,
  output logic [WG_W-1:0]  kdw_data,
  output logic             kdw_write
);

  localparam int CNT_W = $clog2(KDW_N_ELEM + 1);
  localparam int KC_W  = $clog2(KK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  total_r, iss_r, rcv_r;
  logic [KC_W-1:0]   k_r;
  logic [NCH_W-1:0]  ch_r;
  logic [KA_W-1:0]   wa_r;
  logic [MA_W-1:0]   mem_addr_r;
  logic              mem_req_r, busy_r, done_r, kdw_write_r;
  logic [KA_W-1:0]   kdw_addr_r;
  logic [WG_W-1:0]   kdw_data_r;

  logic [NCH_W-1:0]  nch_sat_s;
  logic [CNT_W-1:0]  total_s;
  logic              accept_s, hs_s, last_hs_s, resp_s;

  assign nch_sat_s = (n_ch > NCH_W'(N_CH)) ? NCH_W'(N_CH) : n_ch;
  assign total_s   = CNT_W'(nch_sat_s * KK);
  assign accept_s  = start && (state_r == IDLE);
  assign hs_s      = (state_r == FETCH) && mem_ready;
  assign last_hs_s = hs_s && (iss_r == total_r - CNT_W'(1));
  // Responses outside FETCH/DRAIN (e.g. left over from a reset) are dropped.
  assign resp_s    = mem_rvalid && ((state_r == FETCH) || (state_r == DRAIN))
                     && (rcv_r != total_r);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (total_s == CNT_W'(0)) ? DONE : FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (last_hs_s) state_s = DRAIN;
        else           state_s = FETCH;
      end
      DRAIN: begin
        if (rcv_r == total_r) state_s = DONE;
        else                  state_s = DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and status outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      mem_req_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      mem_req_r <= (state_s == FETCH);
      busy_r    <= (state_s == FETCH) || (state_s == DRAIN);
      done_r    <= (state_s == DONE);
    end
  end

  // Request side: issue counter and running read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_r    <= '0;
      iss_r      <= '0;
      mem_addr_r <= '0;
    end else if (accept_s) begin
      total_r    <= total_s;
      iss_r      <= '0;
      mem_addr_r <= base_addr;
    end else if (hs_s) begin
      iss_r      <= iss_r + CNT_W'(1);
      mem_addr_r <= mem_addr_r + MA_W'(1);
    end
  end

  // Response side: tap/channel counters build the tile address by stepping N_CH per tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv_r <= '0;
      k_r   <= '0;
      ch_r  <= '0;
      wa_r  <= '0;
    end else if (accept_s) begin
      rcv_r <= '0;
      k_r   <= '0;
      ch_r  <= '0;
      wa_r  <= '0;
    end else if (resp_s) begin
      rcv_r <= rcv_r + CNT_W'(1);
      if (k_r == KC_W'(KK - 1)) begin
        k_r  <= '0;
        ch_r <= ch_r + NCH_W'(1);
        wa_r <= KA_W'(ch_r + NCH_W'(1));
      end else begin
        k_r  <= k_r + KC_W'(1);
        wa_r <= wa_r + KA_W'(N_CH);
      end
    end
  end

  // Tile RAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kdw_write_r <= 1'b0;
      kdw_addr_r  <= '0;
      kdw_data_r  <= '0;
    end else begin
      kdw_write_r <= resp_s;
      if (resp_s) begin
        kdw_addr_r <= wa_r;
        kdw_data_r <= mem_rdata;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign kdw_write = kdw_write_r;
  assign kdw_addr  = kdw_addr_r;
  assign kdw_data  = kdw_data_r;

endmodule
